// File: rtl/core_pkg.sv
// Shared decode definitions: op classes, RV32I opcodes, micro-op layout and decode FSM states.
package core_pkg;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_BRANCH = 3'd1,
    CLS_JAL    = 3'd2,
    CLS_JALR   = 3'd3,
    CLS_LOAD   = 3'd4,
    CLS_STORE  = 3'd5,
    CLS_LUI    = 3'd6,
    CLS_AUIPC  = 3'd7
  } op_cls_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] WFI_INS = 32'h10500073;

  typedef struct packed {
    op_cls_t     cls;
    logic [3:0]  fn;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        src2_imm;
    logic [31:0] imm;
    logic        ill;
  } uop_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WFI_HOLD = 2'd2,
    ST_HALT     = 2'd3
  } idu_state_t;

endpackage

// File: rtl/idu_if.sv
// Fetch->decode and decode->ALU handshake bundles; master is the producing side.
interface ifu_idu_if;
  logic        ifu_idu_vld;
  logic [31:0] ifu_idu_ins;
  logic [31:0] ifu_idu_pc;
  logic        idu_ifu_rdy;
  logic        idu_ifu_wfi;

  modport master (output ifu_idu_vld, ifu_idu_ins, ifu_idu_pc,
                  input  idu_ifu_rdy, idu_ifu_wfi);
  modport slave  (input  ifu_idu_vld, ifu_idu_ins, ifu_idu_pc,
                  output idu_ifu_rdy, idu_ifu_wfi);
endinterface

interface idu_alu_if;
  logic        idu_alu_vld;
  logic [2:0]  idu_alu_cls;
  logic [3:0]  idu_alu_fn;
  logic [4:0]  idu_alu_rs1;
  logic [4:0]  idu_alu_rs2;
  logic [4:0]  idu_alu_rd;
  logic        idu_alu_rd_we;
  logic        idu_alu_src2_imm;
  logic [31:0] idu_alu_imm;
  logic [31:0] idu_alu_pc;
  logic        idu_alu_ill;
  logic        alu_idu_rdy;
  logic        alu_ifu_br_vld;

  modport master (output idu_alu_vld, idu_alu_cls, idu_alu_fn, idu_alu_rs1, idu_alu_rs2,
                         idu_alu_rd, idu_alu_rd_we, idu_alu_src2_imm, idu_alu_imm,
                         idu_alu_pc, idu_alu_ill,
                  input  alu_idu_rdy, alu_ifu_br_vld);
  modport slave  (input  idu_alu_vld, idu_alu_cls, idu_alu_fn, idu_alu_rs1, idu_alu_rs2,
                         idu_alu_rd, idu_alu_rd_we, idu_alu_src2_imm, idu_alu_imm,
                         idu_alu_pc, idu_alu_ill,
                  output alu_idu_rdy, alu_ifu_br_vld);
endinterface

// File: rtl/idu_dec.sv
// Combinational RV32I decode of one instruction word into a micro-op.
module idu_dec
  import core_pkg::*;
(
  input  logic [31:0] ins_i,
  output uop_t        uop_o,
  output logic        is_wfi_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        wr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = ins_i[6:0];
  assign f3    = ins_i[14:12];
  assign imm_i = {{20{ins_i[31]}}, ins_i[31:20]};
  assign imm_s = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
  assign imm_b = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
  assign imm_u = {ins_i[31:12], 12'b0};
  assign imm_j = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
  assign is_wfi_o = (ins_i == WFI_INS);

  always_comb begin
    uop_o          = '0;
    uop_o.cls      = CLS_ALU;
    uop_o.fn       = {1'b0, f3};
    uop_o.rs1      = ins_i[19:15];
    uop_o.rs2      = ins_i[24:20];
    uop_o.rd       = ins_i[11:7];
    wr             = 1'b0;
    case (opc)
      OPC_LUI:    begin uop_o.cls = CLS_LUI;    uop_o.imm = imm_u; uop_o.src2_imm = 1'b1; wr = 1'b1; end
      OPC_AUIPC:  begin uop_o.cls = CLS_AUIPC;  uop_o.imm = imm_u; uop_o.src2_imm = 1'b1; wr = 1'b1; end
      OPC_JAL:    begin uop_o.cls = CLS_JAL;    uop_o.imm = imm_j; uop_o.src2_imm = 1'b1; wr = 1'b1; end
      OPC_JALR:   begin uop_o.cls = CLS_JALR;   uop_o.imm = imm_i; uop_o.src2_imm = 1'b1; wr = 1'b1; end
      OPC_BRANCH: begin uop_o.cls = CLS_BRANCH; uop_o.imm = imm_b; end
      OPC_LOAD:   begin uop_o.cls = CLS_LOAD;   uop_o.imm = imm_i; uop_o.src2_imm = 1'b1; wr = 1'b1; end
      OPC_STORE:  begin uop_o.cls = CLS_STORE;  uop_o.imm = imm_s; uop_o.src2_imm = 1'b1; end
      OPC_OP_IMM: begin
        // only the right-shift encoding carries funct7[5] (SRAI vs SRLI)
        uop_o.fn       = {(f3 == 3'b101) & ins_i[30], f3};
        uop_o.imm      = imm_i;
        uop_o.src2_imm = 1'b1;
        wr             = 1'b1;
      end
      OPC_OP:       begin uop_o.fn = {ins_i[30], f3}; wr = 1'b1; end
      OPC_MISC_MEM: ;
      OPC_SYSTEM:   uop_o.ill = ~is_wfi_o;
      default:      uop_o.ill = 1'b1;
    endcase
    uop_o.rd_we = wr & (uop_o.rd != 5'd0) & ~uop_o.ill;
  end

endmodule

// File: rtl/idu.sv
// Instruction decode unit: fetch handshake, registered micro-op, flush and WFI halt/restart.
//   state    | meaning
//   IDLE     | after reset, waiting for start_vld
//   RUN      | accepting and issuing instructions
//   WFI_HOLD | WFI accepted, waiting for ALU to drain or a redirect
//   HALT     | fetch stopped (wfi=1), waiting for start_vld
module idu
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_vld,
  ifu_idu_if.slave   ifu,
  idu_alu_if.master  alu
);

  idu_state_t state_q, state_d;
  uop_t       dec_uop, uop_q, uop_d;
  logic [31:0] pc_q, pc_d;
  logic       dec_wfi, vld_q, vld_d, wfi_q, wfi_d, rdy, accept;

  idu_dec u_dec (.ins_i(ifu.ifu_idu_ins), .uop_o(dec_uop), .is_wfi_o(dec_wfi));

  assign rdy    = (state_q == ST_RUN) & ~alu.alu_ifu_br_vld & (~vld_q | alu.alu_idu_rdy);
  assign accept = ifu.ifu_idu_vld & rdy;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_vld) state_d = ST_RUN;
      ST_RUN:      if (accept && dec_wfi) state_d = ST_WFI_HOLD;
      ST_WFI_HOLD: begin
        if (alu.alu_ifu_br_vld)   state_d = ST_RUN;
        else if (alu.alu_idu_rdy) state_d = ST_HALT;
      end
      ST_HALT:     if (start_vld) state_d = ST_RUN;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_d = vld_q;
    uop_d = uop_q;
    pc_d  = pc_q;
    wfi_d = (state_d == ST_HALT);
    if (alu.alu_ifu_br_vld) begin
      vld_d = 1'b0;
    end else if (accept && !dec_wfi) begin
      vld_d = 1'b1;
      uop_d = dec_uop;
      pc_d  = ifu.ifu_idu_pc;
    end else if (alu.alu_idu_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      uop_q <= '0;
      pc_q  <= '0;
      wfi_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      uop_q <= uop_d;
      pc_q  <= pc_d;
      wfi_q <= wfi_d;
    end
  end

  assign ifu.idu_ifu_rdy      = rdy;
  assign ifu.idu_ifu_wfi      = wfi_q;
  assign alu.idu_alu_vld      = vld_q;
  assign alu.idu_alu_cls      = uop_q.cls;
  assign alu.idu_alu_fn       = uop_q.fn;
  assign alu.idu_alu_rs1      = uop_q.rs1;
  assign alu.idu_alu_rs2      = uop_q.rs2;
  assign alu.idu_alu_rd       = uop_q.rd;
  assign alu.idu_alu_rd_we    = uop_q.rd_we;
  assign alu.idu_alu_src2_imm = uop_q.src2_imm;
  assign alu.idu_alu_imm      = uop_q.imm;
  assign alu.idu_alu_pc       = pc_q;
  assign alu.idu_alu_ill      = uop_q.ill;

endmodule
